// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owners, counter width.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
// Contents: arb_state_t, arb_owner_t, cnt_width().
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    // Bits needed to hold a latency count of 0..latency.
    function automatic int cnt_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store, memory and stall signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their valid pulse; stall freezes the core meanwhile.
// Modports: master = core + memory side, slave = arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // fetch port
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_valid;
    // load/store port
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_valid;
    // memory port
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    // core stall
    logic                  stall;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_valid, d_rdata, d_valid,
               mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_valid, d_rdata, d_valid,
               mem_en, mem_we, mem_addr, mem_wdata, stall
    );

endinterface

// File: rtl/mem_arb_latency_cnt.sv
// Loadable down-counter that times the fixed memory read latency.
// Latency: load takes effect at the next edge; done is combinational on the count.
// Backpressure: none; counts down to zero and parks there.
// Ports: clk, rst (sync, active high), load, load_val, done (count == 1).
module mem_arb_latency_cnt #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign done = (cnt == WIDTH'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between instruction fetch and load/store.
// Latency: request seen in IDLE at T -> valid at T+MEM_LATENCY+2; one IDLE cycle between grants.
// Backpressure: requesters hold req until valid; stall is high while any request is outstanding.
// Ports: clk, rst (sync, active high), bus (mem_port_arbiter_if.slave).
// Build option: ARB_ROUND_ROBIN_EN makes collisions alternate owners; default gives load/store priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int CW = cnt_width(MEM_LATENCY);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be within 1..15");
    end

    if ($bits(bus.mem_addr) != ADDR_WIDTH || $bits(bus.mem_wdata) != DATA_WIDTH) begin : g_bad_width
        $error("mem_port_arbiter: interface widths differ from ADDR_WIDTH/DATA_WIDTH");
    end

    arb_state_t            state;
    arb_owner_t            owner;
    arb_owner_t            gnt;
    logic                  lat_we;
    logic                  any_req;
    logic                  cnt_done;
    logic [ADDR_WIDTH-1:0] gnt_addr;

    assign any_req  = bus.if_req | bus.d_req;
    assign gnt_addr = (gnt == OWN_D) ? bus.d_addr : bus.if_addr;

`ifdef ARB_ROUND_ROBIN_EN
    // Owner granted most recently; on a collision the other one goes first.
    arb_owner_t last_owner;

    always_comb begin
        gnt = OWN_IF;
        if (bus.d_req && bus.if_req) begin
            gnt = (last_owner == OWN_D) ? OWN_IF : OWN_D;
        end else if (bus.d_req) begin
            gnt = OWN_D;
        end
    end
`else
    // The load/store belongs to the older instruction, so it always goes first.
    always_comb begin
        gnt = bus.d_req ? OWN_D : OWN_IF;
    end
`endif

    mem_arb_latency_cnt #(
        .WIDTH (CW)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ISSUE),
        .load_val (CW'(MEM_LATENCY)),
        .done     (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            lat_we        <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
            bus.if_valid  <= 1'b0;
            bus.d_valid   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner    <= OWN_IF;
`endif
        end else begin
            // Strobes and completion pulses last exactly one cycle.
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.if_valid <= 1'b0;
            bus.d_valid  <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner        <= gnt;
                        bus.mem_en   <= 1'b1;
                        bus.mem_addr <= gnt_addr;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner   <= gnt;
`endif
                        if (gnt == OWN_D) begin
                            lat_we        <= bus.d_we;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_wdata <= bus.d_wdata;
                        end else begin
                            // Fetches never write; mem_wdata keeps its last value.
                            lat_we <= 1'b0;
                        end
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    state <= WAIT;
                end

                WAIT: begin
                    // mem_rdata is only trusted on the last WAIT cycle.
                    if (cnt_done) begin
                        if (owner == OWN_D) begin
                            if (!lat_we) begin
                                bus.d_rdata <= bus.mem_rdata;
                            end
                            bus.d_valid <= 1'b1;
                        end else begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_valid <= 1'b1;
                        end
                        state <= RESP;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.stall = (bus.if_req & ~bus.if_valid) | (bus.d_req & ~bus.d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a fixed-latency memory model.
// Latency: expects valid LAT+2 cycles after a grant and the memory strobe 1 cycle after it.
// Backpressure: requesters hold req until valid and may chain a new request right after it.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    parameter int LAT = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int P   = LAT + 3;   // grant-to-grant spacing for chained requests

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    logic mon_en = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [9:0] i);
        return (i == 10'h040) ? 32'h0050_0093 : {6'h2A, i, 6'h15, i};
    endfunction

    // Memory model: data is driven only on the one cycle it is valid.
    logic [31:0] mem [0:1023];
    int          rd_cnt = 0;
    logic [31:0] rd_dat = '0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(10'(i));
        end
        if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
            end else begin
                rd_cnt <= LAT;
                rd_dat <= mem[bus.mem_addr[11:2]];
            end
        end
    end

    assign bus.mem_rdata = (rd_cnt == 1) ? rd_dat : 32'hBAD0_0BAD;

    // Reference model and scoreboards.
    typedef struct {
        arb_owner_t  own;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          due;
    } mexp_t;

    exp_t        sbq [$];
    mexp_t       mq  [$];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] m_d_rdata = '0;

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int due);
        mexp_t m;
        m.we = we; m.addr = addr; m.wdata = wdata; m.due = due;
        mq.push_back(m);
    endtask

    // Transaction granted in IDLE cycle g.
    task automatic expect_txn(input arb_owner_t own, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int g);
        exp_t e;
        push_mem(we, addr, wdata, g + 1);
        e.own = own;
        e.due = g + LAT + 2;
        if (we) begin
            ref_mem[addr[11:2]] = wdata;
            e.rdata = m_d_rdata;
        end else begin
            e.rdata = ref_mem[addr[11:2]];
            if (own == OWN_D) m_d_rdata = e.rdata;
        end
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        mexp_t m;
        if (mon_en) begin
            if (bus.if_valid || bus.d_valid) begin
                chk("one_valid", bus.if_valid & bus.d_valid, 0);
                chk("sb_nonempty", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("owner", bus.d_valid ? OWN_D : OWN_IF, e.own);
                    chk("rdata", bus.d_valid ? bus.d_rdata : bus.if_rdata, e.rdata);
                    chk("valid_cycle", cyc, e.due);
                end
            end
            if (bus.mem_en) begin
                chk("mem_expected", mq.size() > 0, 1);
                if (mq.size() > 0) begin
                    m = mq.pop_front();
                    chk("mem_cycle", cyc, m.due);
                    chk("mem_we", bus.mem_we, m.we);
                    chk("mem_addr", bus.mem_addr, m.addr);
                    if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
                end
            end else begin
                chk("mem_we_idle", bus.mem_we, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        m_d_rdata = '0;
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_d_valid", bus.d_valid, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_stall", bus.stall, 0);
    endtask

    // Drive one request and hold it until its valid; keep=1 leaves req high for a chained request.
    task automatic run_req(input arb_owner_t own, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit keep);
        logic seen;
        logic other;
        seen = 1'b0;
        if (own == OWN_D) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        #1 chk("stall_req", bus.stall, 1);
        for (int n = 0; n < 64; n++) begin
            tick();
            if ((own == OWN_D) ? bus.d_valid : bus.if_valid) begin
                seen = 1'b1;
                break;
            end
            chk("stall_wait", bus.stall, 1);
        end
        chk("valid_seen", seen, 1);
        other = (own == OWN_D) ? bus.if_req : bus.d_req;
        if (seen) chk("stall_resp", bus.stall, other);
        tick();
        if (!keep) begin
            if (own == OWN_D) bus.d_req = 1'b0;
            else bus.if_req = 1'b0;
        end
    endtask

    task automatic solo(input arb_owner_t own, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        expect_txn(own, we, addr, wdata, cyc);
        run_req(own, we, addr, wdata, 1'b0);
    endtask

    initial begin
        int c;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(10'(i));
        rst = 1'b1;
        mem_clr = 1'b1;
        idle_inputs();
        tick();
        mem_clr = 1'b0;
        do_reset();
        mon_en = 1'b1;

        // Fetch only.
        solo(OWN_IF, 1'b0, 32'h100, 32'h0);
        chk("fetch_word", bus.if_rdata, 32'h0050_0093);

        // Load, store, then load back the stored word.
        solo(OWN_D, 1'b0, 32'h300, 32'h0);
        solo(OWN_D, 1'b1, 32'h200, 32'hDEAD_BEEF);
        solo(OWN_D, 1'b0, 32'h200, 32'h0);
        chk("load_back", bus.d_rdata, 32'hDEAD_BEEF);

        // Simultaneous fetch and load out of reset: load first in either mode.
        do_reset();
        c = cyc;
        expect_txn(OWN_D, 1'b0, 32'h40, 32'h0, c);
        expect_txn(OWN_IF, 1'b0, 32'h44, 32'h0, c + P);
        fork
            run_req(OWN_D, 1'b0, 32'h40, 32'h0, 1'b0);
            run_req(OWN_IF, 1'b0, 32'h44, 32'h0, 1'b0);
        join

        // Chained loads/stores against a waiting fetch.
        do_reset();
        c = cyc;
        expect_txn(OWN_D, 1'b0, 32'h80, 32'h0, c);
`ifdef ARB_ROUND_ROBIN_EN
        expect_txn(OWN_IF, 1'b0, 32'h88, 32'h0, c + P);
        expect_txn(OWN_D, 1'b1, 32'h84, 32'hCAFE_F00D, c + 2 * P);
`else
        expect_txn(OWN_D, 1'b1, 32'h84, 32'hCAFE_F00D, c + P);
        expect_txn(OWN_IF, 1'b0, 32'h88, 32'h0, c + 2 * P);
`endif
        fork
            begin
                run_req(OWN_D, 1'b0, 32'h80, 32'h0, 1'b1);
                run_req(OWN_D, 1'b1, 32'h84, 32'hCAFE_F00D, 1'b0);
            end
            run_req(OWN_IF, 1'b0, 32'h88, 32'h0, 1'b0);
        join

        // Reset while waiting on memory: the fetch is abandoned with no valid.
        c = cyc;
        push_mem(1'b0, 32'h104, 32'h0, c + 1);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h104;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.if_req = 1'b0;
        m_d_rdata = '0;
        chk("abort_state", dut.state, IDLE);
        chk("abort_mem_en", bus.mem_en, 0);
        chk("abort_if_rdata", bus.if_rdata, 0);
        chk("abort_d_rdata", bus.d_rdata, 0);
        repeat (LAT + 4) tick();
        solo(OWN_IF, 1'b0, 32'h104, 32'h0);
        solo(OWN_D, 1'b0, 32'h84, 32'h0);

        repeat (4) tick();
        chk("sb_drained", sbq.size(), 0);
        chk("mem_drained", mq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch path and the load/store path of the RISC-V core.
- Used when the core runs against a unified instruction/data memory.
- Arbitrates competing requests, sequences each memory access through an issue/wait/response FSM, and drives a stall signal that freezes PC and pipeline registers while any access is outstanding.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, memory word width.
- MEM_LATENCY, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_valid.
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req is high.
- if_rdata  out  DATA_WIDTH  fetched instruction.
- if_valid  out  1  one-cycle fetch completion pulse.
- d_req  in  1  load/store request; held high until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_rdata  out  DATA_WIDTH  load data.
- d_valid  out  1  one-cycle data completion pulse (load or store).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- stall  out  1  core stall.

Behaviour:

FSM states and transitions:
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is pending, pick an owner (D or IF), latch that owner's addr/we/wdata, and go to ISSUE.
  - Fetch requests always latch we=0.
  - With no request pending, stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched registers.
  - Load cnt=MEM_LATENCY and go to WAIT.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==1, capture mem_rdata into the owner's rdata register at that edge and go to RESP.
  - WAIT therefore lasts exactly MEM_LATENCY cycles.
- RESP (1 cycle):
  - The owner's valid=1; go to IDLE.

Handshake rules:
- Latency: a request first seen in IDLE at cycle T gives valid at cycle T+MEM_LATENCY+2 (T+4 at the default).
- The requester must drop req in the cycle after valid unless it is issuing a new request.
- An IDLE cycle always separates transactions; there are no back-to-back grants.
- On stores, d_valid is a write acknowledge and d_rdata keeps its previous value.
- Arbitration: if d_req and if_req are both high in IDLE, D wins. Rationale: the load/store belongs to the older instruction, and fetch must wait for it.
- if_rdata and d_rdata hold their value until the next capture for the same owner.

Outputs outside ISSUE:
- mem_en=0 and mem_we=0.
- mem_addr and mem_wdata hold their last value.

stall:
- Combinational: stall = (if_req & ~if_valid) | (d_req & ~d_valid).
- stall is 0 in the RESP cycle for the completing owner, unless the other owner is still requesting.

Reset (rst=1 at any edge):
- State goes to IDLE, cnt=0.
- if_valid, d_valid, mem_en and mem_we go to 0.
- rdata registers, mem_addr and mem_wdata go to 0.
- Reset mid-transaction abandons the transaction; no valid is produced for it. A store already strobed is not undone.

Error handling:
- A request dropped before its valid is a protocol error. The transaction still completes, and valid is generated regardless.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a last_owner register (reset to IF) is added. On a simultaneous request in IDLE, the owner that was not granted most recently wins, so sustained data traffic cannot starve fetch.
- Undefined: fixed priority, D always wins; no last_owner register.

Decomposition:
- Shared package mem_arb_pkg holds:
  - enum arb_state_t {IDLE, ISSUE, WAIT, RESP}.
  - enum arb_owner_t {OWN_IF, OWN_D}.
  - localparam function for the counter width: $clog2(MEM_LATENCY+1).
- One sub-module, mem_arb_latency_cnt: a loadable down-counter with a load input, a load value, and a done output (cnt==1).

Test Plan:
1. Fetch only, MEM_LATENCY=2: if_req=1, if_addr=0x100 at T; memory model returns 0x00500093 two cycles after mem_en. Expect mem_en at T+1 with mem_addr=0x100, if_valid at T+4 with if_rdata=0x00500093, stall=1 for T..T+3 and 0 at T+4.
2. Store: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF. Expect a single mem_en/mem_we pulse with those values, d_valid at T+4, d_rdata unchanged, and a subsequent load of 0x200 returning 0xDEADBEEF.
3. Simultaneous if_req and d_req at T with the macro off: D is served first (d_valid at T+4), IF is served next (mem_en at T+6, if_valid at T+9); stall stays high until T+9.
4. With ARB_ROUND_ROBIN_EN, three consecutive collisions starting from reset: grants go D, IF, D.
5. rst asserted during WAIT: next cycle state is IDLE, no valid pulse for the abandoned transaction; a re-issued fetch then completes normally.
6. Parameter sweep with MEM_LATENCY=1 and 15: req-to-valid latency is exactly MEM_LATENCY+2, and mem_rdata is sampled only at the WAIT edge where cnt==1.
